ahb_mem_arbiter: RTL and testbench
==================================

# ahb_mem_arbiter

Two-port AHB-Lite arbiter that shares the single on-chip memory between two masters: port 0 is the CPU side and port 1 is the DMA/debug side. Each port behaves as an AHB-Lite slave with wait states. The block captures each address phase, picks one port per memory access with round-robin priority, and drives a single synchronous SRAM port with byte enables. It sits between the bus fabric and the memory, in place of a direct AHB-to-memory bridge.

## Interface
- ADDR_WIDTH, 32, width of HADDR and mem_addr
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sN_HSEL  in  1  port N slave select (N = 0, 1; all sN_ ports repeat per port)
- sN_HREADY  in  1  port N bus ready; an address phase is accepted only when this is high
- sN_HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- sN_HSIZE  in  3  000 = byte, 001 = half, 01x/1xx = word
- sN_HWRITE  in  1  1 = write
- sN_HADDR  in  ADDR_WIDTH  byte address
- sN_HWDATA  in  32  write data, valid in the data phase
- sN_HRDATA  out  32  read data (= mem_rdata)
- sN_HREADYOUT  out  1  0 = wait state
- sN_HRESP  out  1  tied 0 (OKAY)
- mem_en  out  1  memory access strobe
- mem_we  out  1  write when mem_en is high
- mem_be  out  4  byte enables, little-endian lanes
- mem_addr  out  ADDR_WIDTH  byte address, passed through unmodified
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after a read strobe

## Operation
- **Accept.** At a rising edge with sN_HSEL & sN_HTRANS[1] & sN_HREADY:
  - set pend_N.
  - register the address, size and write flag.
  - The port is now in its data phase.
- **Ignored transfers.** IDLE/BUSY transfers and unselected cycles do not set pend_N.
- **FSM states.**
  - IDLE: arbitration happens here.
  - RD: a read was issued last cycle and its data returns this cycle.
- **Arbitration in IDLE.** Combinational, over the registered pend_0 and pend_1.
  - Only one pending: grant that port.
  - Both pending: grant the port that is not rr_last, then set rr_last to the granted port.
- **Granted write (IDLE).**
  - mem_en=1, mem_we=1, mem_wdata = sN_HWDATA (live data-phase value).
  - Same cycle: sN_HREADYOUT=1 and pend_N clears, unless a new address phase is accepted in the same cycle.
  - FSM stays in IDLE.
- **Granted read (IDLE).** mem_en=1, mem_we=0, sN_HREADYOUT=0, next state RD.
- **RD state.**
  - The granted port gets sN_HREADYOUT=1; sN_HRDATA = mem_rdata.
  - pend_N clears (or reloads); next state IDLE.
  - No new grant is made in RD.
- **Byte enables.** From the registered size and addr[1:0]:
  - byte: 0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
  - Misaligned accesses are not checked.
- **HREADYOUT rules.** A port with pend_N=0 drives HREADYOUT=1. A pending port that is not completing drives 0.
- **Idle memory outputs.** When no access is issued, mem_en, mem_we, mem_be, mem_addr and mem_wdata are all 0.

## Timing
- **Reset values.**
  - state = IDLE, pend_0 = pend_1 = 0, rr_last = 1 (port 0 wins the first tie).
  - sN_HREADYOUT = 1, sN_HRESP = 0.
  - All mem_* outputs = 0.
  - Reset mid-read drops the access; no completion is signalled after reset.
- **Uncontested write.** Address phase in cycle A; memory write and HREADYOUT=1 in cycle A+1 (zero wait states).
- **Uncontested read.** Address phase in cycle A; mem_en in A+1 with HREADYOUT=0; data and HREADYOUT=1 in A+2 (one wait state).
- **Losing port.** HREADYOUT stays low until it is granted. The master holds its data-phase signals stable meanwhile, per AHB.
- **Contended write-write.** Loser completes one cycle after the winner.
- **Contended read.** A read winner blocks the other port for 2 cycles.
- **Pipelining.** A completing port may present its next address phase in its completion cycle. It is captured and arbitrated from the next cycle.
- **Simultaneous accept and complete on one port.** The new capture wins: pend_N stays 1 with the new attributes.

## Test plan
- **Port 0 word write, uncontested.** Address 0x100, data 0xDEADBEEF. Next cycle: mem_en=1, mem_we=1, mem_be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF, s0_HREADYOUT=1.
- **Port 1 word read, uncontested.** Address 0x104; memory returns 0x12345678. s1_HREADYOUT=0 for one cycle, then 1 with s1_HRDATA=0x12345678.
- **Both ports write in the same cycle.** Port 0 at 0x10, port 1 at 0x20.
  - Port 0 is written first; port 1 is written the next cycle and its HREADYOUT is low for exactly one cycle.
  - A repeat tie serves port 1 first.
- **Sub-word writes from port 0.**
  - Byte at 0x203 → mem_be=1000.
  - Half at 0x202 → 1100.
  - Half at 0x200 → 0011.
  - Byte at 0x201 → 0010.
- **Back-to-back pipelined reads on both ports for 8 transfers each.** Grants alternate 0,1,0,1…; every read returns the correct word; no transfer is lost or duplicated.
- **Reset during RD state.**
  - All outputs take their reset values immediately: HREADYOUT=1, mem_en=0.
  - After release, a single port 1 write completes with zero wait states.

Source files
------------

// File: rtl/ahb_mem_arbiter.sv
// Two-port AHB-Lite arbiter in front of one synchronous SRAM port.
// Port 0 is the CPU side, port 1 the DMA/debug side. Each port captures its
// address phase into a pending slot; one slot is served per memory access with
// round-robin priority on ties. Writes finish with zero wait states and reads
// with one wait state.
module ahb_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // Port 0 (CPU)
  input  logic                  s0_HSEL,
  input  logic                  s0_HREADY,
  input  logic [1:0]            s0_HTRANS,
  input  logic [2:0]            s0_HSIZE,
  input  logic                  s0_HWRITE,
  input  logic [ADDR_WIDTH-1:0] s0_HADDR,
  input  logic [31:0]           s0_HWDATA,
  output logic [31:0]           s0_HRDATA,
  output logic                  s0_HREADYOUT,
  output logic                  s0_HRESP,
  // Port 1 (DMA/debug)
  input  logic                  s1_HSEL,
  input  logic                  s1_HREADY,
  input  logic [1:0]            s1_HTRANS,
  input  logic [2:0]            s1_HSIZE,
  input  logic                  s1_HWRITE,
  input  logic [ADDR_WIDTH-1:0] s1_HADDR,
  input  logic [31:0]           s1_HWDATA,
  output logic [31:0]           s1_HRDATA,
  output logic                  s1_HREADYOUT,
  output logic                  s1_HRESP,
  // SRAM port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic {StIdle, StRd} state_e;

  state_e                r_state, w_state_d;
  logic [1:0]            r_pend;
  logic [ADDR_WIDTH-1:0] r_addr [2];
  logic [2:0]            r_size [2];
  logic [1:0]            r_write;
  logic                  r_rr_last, w_rr_last_d;
  logic                  r_rd_port, w_rd_port_d;

  logic [1:0]            w_accept;
  logic [1:0]            w_complete;
  logic                  w_issue;
  logic                  w_gnt;
  logic [2:0]            w_sel_size;
  logic [1:0]            w_sel_lo;
  logic [3:0]            w_be;
  logic                  w_unused;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign w_unused = s0_HTRANS[0] ^ s1_HTRANS[0];

  assign w_accept[0] = s0_HSEL & s0_HTRANS[1] & s0_HREADY;
  assign w_accept[1] = s1_HSEL & s1_HTRANS[1] & s1_HREADY;

  // Address-phase capture; a new capture overrides a same-cycle completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend    <= '0;
      r_write   <= '0;
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_size[0] <= '0;
      r_size[1] <= '0;
    end else begin
      r_pend <= w_accept | (r_pend & ~w_complete);
      if (w_accept[0]) begin
        r_addr[0]  <= s0_HADDR;
        r_size[0]  <= s0_HSIZE;
        r_write[0] <= s0_HWRITE;
      end
      if (w_accept[1]) begin
        r_addr[1]  <= s1_HADDR;
        r_size[1]  <= s1_HSIZE;
        r_write[1] <= s1_HWRITE;
      end
    end
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_rr_last <= 1'b1;
      r_rd_port <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rr_last <= w_rr_last_d;
      r_rd_port <= w_rd_port_d;
    end
  end

  // Grant selection, completion strobes and next state.
  always_comb begin
    w_state_d   = r_state;
    w_rr_last_d = r_rr_last;
    w_rd_port_d = r_rd_port;
    w_complete  = '0;
    w_issue     = 1'b0;
    w_gnt       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|r_pend) begin
          w_issue = 1'b1;
          if (&r_pend) begin
            w_gnt       = ~r_rr_last;
            w_rr_last_d = ~r_rr_last;
          end else begin
            w_gnt = r_pend[1];
          end
          if (r_write[w_gnt]) begin
            w_complete[w_gnt] = 1'b1;
          end else begin
            w_state_d   = StRd;
            w_rd_port_d = w_gnt;
          end
        end
      end
      StRd: begin
        // Read data is on mem_rdata this cycle; no new grant here.
        w_complete[r_rd_port] = 1'b1;
        w_state_d             = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Byte-lane enables from the granted port's registered size and offset.
  always_comb begin
    w_sel_size = r_size[w_gnt];
    w_sel_lo   = r_addr[w_gnt][1:0];
    case (w_sel_size)
      3'b000:  w_be = 4'b0001 << w_sel_lo;
      3'b001:  w_be = w_sel_lo[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Memory strobe; every field is held at zero when nothing is issued.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_issue) begin
      mem_en   = 1'b1;
      mem_we   = r_write[w_gnt];
      mem_be   = w_be;
      mem_addr = r_addr[w_gnt];
      if (r_write[w_gnt]) begin
        mem_wdata = w_gnt ? s1_HWDATA : s0_HWDATA;
      end
    end
  end

  assign s0_HREADYOUT = ~r_pend[0] | w_complete[0];
  assign s1_HREADYOUT = ~r_pend[1] | w_complete[1];
  assign s0_HRDATA    = mem_rdata;
  assign s1_HRDATA    = mem_rdata;
  assign s0_HRESP     = 1'b0;
  assign s1_HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Self-checking bench for ahb_mem_arbiter: two pipelined AHB masters, a
// pattern-returning SRAM model, and scoreboards for memory strobes and read data.
module tb_ahb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_HSEL, s1_HSEL;
  logic        s0_HREADY, s1_HREADY;
  logic [1:0]  s0_HTRANS, s1_HTRANS;
  logic [2:0]  s0_HSIZE, s1_HSIZE;
  logic        s0_HWRITE, s1_HWRITE;
  logic [31:0] s0_HADDR, s1_HADDR;
  logic [31:0] s0_HWDATA, s1_HWDATA;
  logic [31:0] s0_HRDATA, s1_HRDATA;
  logic        s0_HREADYOUT, s1_HREADYOUT;
  logic        s0_HRESP, s1_HRESP;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  // Per-port transfer tables.
  logic [31:0] t_addr [2][16];
  logic [31:0] t_data [2][16];
  logic        t_wr   [2][16];
  logic [2:0]  t_size [2][16];
  int          t_wait [2][16];
  int          t_n    [2];

  logic [68:0] acc_q [$];   // {we, be, addr, wdata}
  logic [31:0] rd_q0 [$];
  logic [31:0] rd_q1 [$];

  always #5 clk = ~clk;

  // Single-slave fabric: bus ready follows this slave's ready.
  assign s0_HREADY = s0_HREADYOUT;
  assign s1_HREADY = s1_HREADYOUT;

  ahb_mem_arbiter #(.ADDR_WIDTH(32)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .s0_HSEL      (s0_HSEL),
    .s0_HREADY    (s0_HREADY),
    .s0_HTRANS    (s0_HTRANS),
    .s0_HSIZE     (s0_HSIZE),
    .s0_HWRITE    (s0_HWRITE),
    .s0_HADDR     (s0_HADDR),
    .s0_HWDATA    (s0_HWDATA),
    .s0_HRDATA    (s0_HRDATA),
    .s0_HREADYOUT (s0_HREADYOUT),
    .s0_HRESP     (s0_HRESP),
    .s1_HSEL      (s1_HSEL),
    .s1_HREADY    (s1_HREADY),
    .s1_HTRANS    (s1_HTRANS),
    .s1_HSIZE     (s1_HSIZE),
    .s1_HWRITE    (s1_HWRITE),
    .s1_HADDR     (s1_HADDR),
    .s1_HWDATA    (s1_HWDATA),
    .s1_HRDATA    (s1_HRDATA),
    .s1_HREADYOUT (s1_HREADYOUT),
    .s1_HRESP     (s1_HRESP),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory contents seen by reads (writes are checked on the strobe instead).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h104) ? 32'h1234_5678 : {8'hA5, a[23:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM model: read data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);
  end

  // Memory-strobe scoreboard.
  always @(negedge clk) begin
    if (mem_en) begin
      if (acc_q.size() == 0) begin
        check_eq("mem_extra_access", acc_q.size(), 1);
      end else begin
        check_eq("mem_access", {mem_we, mem_be, mem_addr, mem_wdata}, acc_q.pop_front());
      end
    end else begin
      check_eq("mem_idle_zero", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
    end
  end

  task automatic push_acc(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d);
    acc_q.push_back({we, be, a, d});
  endtask

  task automatic add_xfer(input int p, input logic wr, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input int waits);
    t_wr[p][t_n[p]]   = wr;
    t_size[p][t_n[p]] = sz;
    t_addr[p][t_n[p]] = a;
    t_data[p][t_n[p]] = d;
    t_wait[p][t_n[p]] = waits;
    t_n[p]++;
  endtask

  task automatic drive_addr(input int p, input logic sel, input logic [1:0] trans,
                            input logic wr, input logic [2:0] sz, input logic [31:0] a);
    if (p == 0) begin
      s0_HSEL = sel; s0_HTRANS = trans; s0_HWRITE = wr; s0_HSIZE = sz; s0_HADDR = a;
    end else begin
      s1_HSEL = sel; s1_HTRANS = trans; s1_HWRITE = wr; s1_HSIZE = sz; s1_HADDR = a;
    end
  endtask

  task automatic drive_wdata(input int p, input logic [31:0] d);
    if (p == 0) s0_HWDATA = d;
    else        s1_HWDATA = d;
  endtask

  // Pipelined AHB master; entered and left at posedge + 1.
  task automatic run_port(input int p);
    int i = 0;
    int dp = -1;
    int waits = 0;
    int guard = 0;
    logic rdy;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    while (i < t_n[p] || dp >= 0) begin
      if (i < t_n[p]) drive_addr(p, 1'b1, 2'b10, t_wr[p][i], t_size[p][i], t_addr[p][i]);
      else            drive_addr(p, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
      drive_wdata(p, (dp >= 0 && t_wr[p][dp]) ? t_data[p][dp] : 32'h0);
      @(negedge clk);
      rdy   = (p == 0) ? s0_HREADYOUT : s1_HREADYOUT;
      rdata = (p == 0) ? s0_HRDATA : s1_HRDATA;
      if (rdy) begin
        if (dp >= 0) begin
          if (t_wait[p][dp] >= 0) check_eq($sformatf("p%0d_waits_%0d", p, dp), waits, t_wait[p][dp]);
          if (!t_wr[p][dp]) begin
            if (((p == 0) ? rd_q0.size() : rd_q1.size()) == 0) begin
              check_eq($sformatf("p%0d_rd_underflow", p), 0, 1);
            end else begin
              exp_rd = (p == 0) ? rd_q0.pop_front() : rd_q1.pop_front();
              check_eq($sformatf("p%0d_rdata_%0d", p, dp), rdata, exp_rd);
            end
          end
        end
        if (i < t_n[p]) begin
          dp = i;
          if (!t_wr[p][i]) begin
            if (p == 0) rd_q0.push_back(mem_word(t_addr[p][i]));
            else        rd_q1.push_back(mem_word(t_addr[p][i]));
          end
          i++;
        end else begin
          dp = -1;
        end
        waits = 0;
      end else begin
        waits++;
      end
      guard++;
      if (guard > 200) begin
        check_eq($sformatf("p%0d_timeout", p), guard, 0);
        break;
      end
      @(posedge clk); #1;
    end
    drive_addr(p, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    drive_wdata(p, 32'h0);
  endtask

  task automatic run_both();
    fork
      if (t_n[0] > 0) run_port(0);
      if (t_n[1] > 0) run_port(1);
    join
    t_n[0] = 0;
    t_n[1] = 0;
  endtask

  initial begin
    t_n[0] = 0;
    t_n[1] = 0;
    reset = 1'b1;
    drive_addr(0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    drive_addr(1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    drive_wdata(0, 32'h0);
    drive_wdata(1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s0_ready", s0_HREADYOUT, 1'b1);
    check_eq("rst_s1_ready", s1_HREADYOUT, 1'b1);
    check_eq("rst_hresp", {s0_HRESP, s1_HRESP}, 2'b00);
    check_eq("rst_mem", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 70'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Tied reads; port 0 wins, then reset lands in the RD state.
    drive_addr(0, 1'b1, 2'b10, 1'b0, 3'b010, 32'h104);
    drive_addr(1, 1'b1, 2'b10, 1'b0, 3'b010, 32'h108);
    push_acc(1'b0, 4'hF, 32'h104, 32'h0);
    @(posedge clk); #1;
    check_eq("tie_rd_s0_wait", s0_HREADYOUT, 1'b0);
    check_eq("tie_rd_s1_wait", s1_HREADYOUT, 1'b0);
    @(posedge clk); #1;
    check_eq("rd_state_s0_done", s0_HREADYOUT, 1'b1);
    check_eq("rd_state_s1_blocked", s1_HREADYOUT, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_rd_s1_ready", s1_HREADYOUT, 1'b1);
    check_eq("rst_rd_mem_en", mem_en, 1'b0);
    drive_addr(0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    drive_addr(1, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", {s0_HREADYOUT, s1_HREADYOUT}, 2'b11);
    add_xfer(1, 1'b1, 3'b010, 32'h30, 32'h3333_3333, 0);
    push_acc(1'b1, 4'hF, 32'h30, 32'h3333_3333);
    run_both();

    // Uncontested word write on port 0.
    add_xfer(0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
    push_acc(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    run_both();

    // Uncontested word read on port 1.
    add_xfer(1, 1'b0, 3'b010, 32'h104, 32'h0, 1);
    push_acc(1'b0, 4'hF, 32'h104, 32'h0);
    run_both();

    // Tied writes: port 0 first, then the repeat tie serves port 1 first.
    add_xfer(0, 1'b1, 3'b010, 32'h10, 32'h1111_1111, 0);
    add_xfer(1, 1'b1, 3'b010, 32'h20, 32'h2222_2222, 1);
    push_acc(1'b1, 4'hF, 32'h10, 32'h1111_1111);
    push_acc(1'b1, 4'hF, 32'h20, 32'h2222_2222);
    run_both();
    add_xfer(0, 1'b1, 3'b010, 32'h14, 32'h4444_4444, 1);
    add_xfer(1, 1'b1, 3'b010, 32'h24, 32'h5555_5555, 0);
    push_acc(1'b1, 4'hF, 32'h24, 32'h5555_5555);
    push_acc(1'b1, 4'hF, 32'h14, 32'h4444_4444);
    run_both();

    // Sub-word writes, back to back on port 0.
    add_xfer(0, 1'b1, 3'b000, 32'h203, 32'hAA00_0000, 0);
    add_xfer(0, 1'b1, 3'b001, 32'h202, 32'hBBBB_0000, 0);
    add_xfer(0, 1'b1, 3'b001, 32'h200, 32'h0000_CCCC, 0);
    add_xfer(0, 1'b1, 3'b000, 32'h201, 32'h0000_DD00, 0);
    push_acc(1'b1, 4'b1000, 32'h203, 32'hAA00_0000);
    push_acc(1'b1, 4'b1100, 32'h202, 32'hBBBB_0000);
    push_acc(1'b1, 4'b0011, 32'h200, 32'h0000_CCCC);
    push_acc(1'b1, 4'b0010, 32'h201, 32'h0000_DD00);
    run_both();

    // Pipelined reads on both ports; grants alternate starting with port 0.
    for (int k = 0; k < 8; k++) begin
      add_xfer(0, 1'b0, 3'b010, 32'h400 + 32'(4 * k), 32'h0, (k == 0) ? 1 : 3);
      add_xfer(1, 1'b0, 3'b010, 32'h600 + 32'(4 * k), 32'h0, 3);
      push_acc(1'b0, 4'hF, 32'h400 + 32'(4 * k), 32'h0);
      push_acc(1'b0, 4'hF, 32'h600 + 32'(4 * k), 32'h0);
    end
    run_both();

    repeat (2) @(posedge clk);
    #1;
    check_eq("acc_q_drained", acc_q.size(), 0);
    check_eq("rd_q_drained", rd_q0.size() + rd_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
